usb_line_arbiter: RTL

Half-duplex line controller for the full-speed USB transceiver. Owns the single D+/D- pair: decides when the bit-level receiver may listen and when the transmitter may drive, drives the transceiver output enable, enforces the inter-packet gap, and times out missing responses after a transmitted packet. Sits between the bit-level block (rx activity/EOP) and the packet-level TX/RX engines.

---
 rtl/usb_line_arbiter_pkg.sv | 16 +
 rtl/usb_line_arbiter_if.sv | 24 ++
 rtl/usb_line_arbiter_line_timer.sv | 34 +++
 rtl/usb_line_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/usb_line_arbiter_pkg.sv
// Shared types and default timing constants for the USB full-speed line arbiter.
package usb_line_arbiter_pkg;

  localparam int DEF_CLKS_PER_BIT    = 5;
  localparam int DEF_IPG_BITS        = 2;
  localparam int DEF_TURNAROUND_BITS = 18;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX        = 3'd1,
    ST_TX        = 3'd2,
    ST_GAP       = 3'd3,
    ST_WAIT_RESP = 3'd4
  } line_state_e;

endpackage

// File: rtl/usb_line_arbiter_if.sv
// Handshake bundle between the line arbiter and the bit/packet engines.
interface usb_line_arbiter_if;

  logic rx_active;
  logic rx_eop;
  logic tx_req;
  logic tx_done;
  logic expect_resp;
  logic tx_gnt;
  logic oe;
  logic timeout;
  logic busy;

  modport master (
    output rx_active, rx_eop, tx_req, tx_done, expect_resp,
    input  tx_gnt, oe, timeout, busy
  );

  modport slave (
    input  rx_active, rx_eop, tx_req, tx_done, expect_resp,
    output tx_gnt, oe, timeout, busy
  );

endinterface

// File: rtl/usb_line_arbiter_line_timer.sv
// Loadable down-counter that holds at zero; shared by the gap and response windows.
module line_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  // "last" lets a registered consumer act in the cycle the count reaches zero
  assign last = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/usb_line_arbiter.sv
// Half-duplex D+/D- line owner: RX/TX arbitration, inter-packet gap, response timeout.
// Optional build macro USB_LINE_STATS_EN adds a saturating timeout_cnt output.
module usb_line_arbiter
  import usb_line_arbiter_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEF_CLKS_PER_BIT,
  parameter int IPG_BITS        = DEF_IPG_BITS,
  parameter int TURNAROUND_BITS = DEF_TURNAROUND_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  usb_line_arbiter_if.slave  line
`ifdef USB_LINE_STATS_EN
  , output logic [7:0]       timeout_cnt
`endif
);

  localparam int TMR_W = $clog2(TURNAROUND_BITS * CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(IPG_BITS * CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] RESP_LOAD = TMR_W'(TURNAROUND_BITS * CLKS_PER_BIT - 1);

  line_state_e      state_q, state_d;
  logic             tx_gnt_q, tx_gnt_d;
  logic             oe_q, oe_d;
  logic             timeout_q, timeout_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic [TMR_W-1:0] tmr_cnt;
  logic             tmr_zero, tmr_last;

  line_timer #(.WIDTH(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero),
    .last     (tmr_last)
  );

  always_comb begin
    state_d      = state_q;
    timeout_d    = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = GAP_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (line.rx_active)   state_d = ST_RX;
        else if (line.tx_req) state_d = ST_TX;
      end
      ST_RX: begin
        if (line.rx_eop) state_d = ST_GAP;
      end
      ST_TX: begin
        if (line.tx_done)     state_d = line.expect_resp ? ST_WAIT_RESP : ST_GAP;
        else if (!line.tx_req) state_d = ST_GAP;
      end
      ST_GAP: begin
        // gap expiry takes the IDLE decision directly so a held tx_req is
        // granted right after the last gap cycle
        if (line.rx_active)   state_d = ST_RX;
        else if (tmr_zero)    state_d = line.tx_req ? ST_TX : ST_IDLE;
      end
      ST_WAIT_RESP: begin
        if (line.rx_active) begin
          state_d = ST_RX;
        end else if (tmr_last) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      if (state_d == ST_GAP) begin
        tmr_load     = 1'b1;
        tmr_load_val = GAP_LOAD;
      end else if (state_d == ST_WAIT_RESP) begin
        tmr_load     = 1'b1;
        tmr_load_val = RESP_LOAD;
      end
    end

    tx_gnt_d = (state_d == ST_TX);
    oe_d     = (state_d == ST_TX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tx_gnt_q  <= 1'b0;
      oe_q      <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_gnt_q  <= tx_gnt_d;
      oe_q      <= oe_d;
      timeout_q <= timeout_d;
    end
  end

  assign line.tx_gnt  = tx_gnt_q;
  assign line.oe      = oe_q;
  assign line.timeout = timeout_q;
  assign line.busy    = (state_q != ST_IDLE);

`ifdef USB_LINE_STATS_EN
  logic [7:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    if (timeout_d && (tcnt_q != 8'hFF)) tcnt_d = tcnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= 8'd0;
    else        tcnt_q <= tcnt_d;
  end

  assign timeout_cnt = tcnt_q;
`endif

endmodule
